// File: rtl/dlx_mem_pkg.sv
// dlx_mem_pkg: size codes, FSM states and lane constants shared by the DLX data-memory controller
package dlx_mem_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int HALF_W = WORD_W / 2;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, GAP, WR, FIN} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/dlx_mem_lane.sv
// dlx_mem_lane: big-endian lane extract/extend for loads and lane merge for sub-word stores
// size_i/off_i/sign_ext_i: access shape; rd_word_i: word read from memory; base_i: word to merge into;
// wdata_i: right-aligned store data; ld_data_o: extended load result; st_word_o: merged store word
module dlx_mem_lane
  import dlx_mem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        off_i,
  input  logic              sign_ext_i,
  input  logic [WORD_W-1:0] rd_word_i,
  input  logic [WORD_W-1:0] base_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] ld_data_o,
  output logic [WORD_W-1:0] st_word_o
);
  logic [4:0] bsh;
  logic [WORD_W-1:0] b_word, mask, lane;
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;
  always_comb begin
    // byte k sits at bit 8*(3-k); {~k,3'b0} is that shift
    bsh = {~off_i, 3'b000};
    b_word = rd_word_i >> bsh;
    b = b_word[BYTE_W-1:0];
    h = off_i[1] ? rd_word_i[HALF_W-1:0] : rd_word_i[WORD_W-1:HALF_W];
    ld_data_o = size_i == SZ_BYTE ? {{(WORD_W-BYTE_W){sign_ext_i & b[BYTE_W-1]}}, b}
              : size_i == SZ_HALF ? {{(WORD_W-HALF_W){sign_ext_i & h[HALF_W-1]}}, h} : rd_word_i;
    mask = size_i == SZ_BYTE ? {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << bsh
         : size_i == SZ_HALF ? (off_i[1] ? {{HALF_W{1'b0}}, {HALF_W{1'b1}}} : {{HALF_W{1'b1}}, {HALF_W{1'b0}}}) : '1;
    lane = size_i == SZ_BYTE ? {{(WORD_W-BYTE_W){1'b0}}, wdata_i[BYTE_W-1:0]} << bsh
         : size_i == SZ_HALF ? (off_i[1] ? {{HALF_W{1'b0}}, wdata_i[HALF_W-1:0]} : {wdata_i[HALF_W-1:0], {HALF_W{1'b0}}}) : wdata_i;
    st_word_o = (base_i & ~mask) | (lane & mask);
  end
endmodule

// File: rtl/dlx_dmem_ctrl.sv
// dlx_dmem_ctrl: byte/half/word load-store controller between the DLX MEM stage and a word-addressed memory
// CPU side: req/rnw/size/sign_ext/addr/wdata in; rdata/done/stall/misalign_err/timeout_err out.
// Memory side: mem_enable/mem_readnotwrite/mem_address/mem_wdata/mem_oe out; mem_rdata/mem_data_ready in.
// Optional: define CTRL_TIMEOUT_EN to abort RD/WR after TIMEOUT_CYCLES extra cycles without mem_data_ready.
module dlx_dmem_ctrl
  import dlx_mem_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int ADDRESS_SIZE   = 16,
  parameter int MIN_WAIT       = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    rnw,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [WORD_SIZE-1:0]    addr,
  input  logic [WORD_SIZE-1:0]    wdata,
  output logic [WORD_SIZE-1:0]    rdata,
  output logic                    done,
  output logic                    stall,
  output logic                    misalign_err,
  output logic                    timeout_err,
  output logic                    mem_enable,
  output logic                    mem_readnotwrite,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]    mem_wdata,
  output logic                    mem_oe,
  input  logic [WORD_SIZE-1:0]    mem_rdata,
  input  logic                    mem_data_ready
);
`ifdef CTRL_TIMEOUT_EN
  localparam int CNT_MAX = MIN_WAIT + TIMEOUT_CYCLES - 2;
`else
  localparam int CNT_MAX = MIN_WAIT - 1;
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif
  localparam int CW = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] RDY_AT = CW'(MIN_WAIT - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic rnw_q, sign_q, done_q, mis_q, to_q, en_q, rnwo_q;
  logic [1:0] size_q, off_q;
  logic [WORD_W-1:0] wd_q, word_q, rdata_q, ld_data, st_word;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic hit, expire, unused_addr;
  assign hit = mem_data_ready && cnt_q >= RDY_AT;
`ifdef CTRL_TIMEOUT_EN
  assign expire = !mem_data_ready && cnt_q == CNT_TOP;
`else
  assign expire = 1'b0;
`endif
  assign unused_addr = ^addr[WORD_SIZE-1:ADDRESS_SIZE+2];
  dlx_mem_lane u_lane (
    .size_i     (size_q),
    .off_i      (off_q),
    .sign_ext_i (sign_q),
    .rd_word_i  (mem_rdata),
    .base_i     (word_q),
    .wdata_i    (wd_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rnw_q <= 1'b0;
      sign_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
      wd_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      rdata_q <= '0;
      done_q <= 1'b0;
      mis_q <= 1'b0;
      to_q <= 1'b0;
      en_q <= 1'b0;
      rnwo_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      mis_q <= 1'b0;
      to_q <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          rnw_q <= rnw;
          size_q <= size;
          off_q <= addr[1:0];
          sign_q <= sign_ext;
          wd_q <= wdata;
          word_q <= wdata;
          addr_q <= addr[ADDRESS_SIZE+1:2];
          rdata_q <= '0;
          cnt_q <= '0;
          if (misaligned(size, addr[1:0])) begin
            state_q <= FIN;
            done_q <= 1'b1;
            mis_q <= 1'b1;
          end else begin
            // loads and sub-word stores both start with a read
            state_q <= (rnw || size != SZ_WORD) ? RD : WR;
            en_q <= 1'b1;
            rnwo_q <= rnw || size != SZ_WORD;
          end
        end
        RD, WR: begin
          cnt_q <= cnt_q == CNT_TOP ? cnt_q : cnt_q + 1'b1;
          if (hit || expire) begin
            cnt_q <= '0;
            en_q <= 1'b0;
            rnwo_q <= 1'b1;
            if (state_q == RD && !rnw_q && hit) begin
              state_q <= GAP;
              word_q <= mem_rdata;
            end else begin
              state_q <= FIN;
              done_q <= 1'b1;
              to_q <= expire;
              if (state_q == RD && rnw_q && hit) rdata_q <= ld_data;
            end
          end
        end
        // enable stays low here so the write phase sees a fresh ENABLE edge
        GAP: begin
          state_q <= WR;
          word_q <= st_word;
          en_q <= 1'b1;
          rnwo_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rdata = rdata_q;
  assign done = done_q;
  assign misalign_err = mis_q;
  assign timeout_err = to_q;
  assign mem_enable = en_q;
  assign mem_readnotwrite = rnwo_q;
  assign mem_address = addr_q;
  assign mem_wdata = word_q;
  assign mem_oe = en_q & ~rnwo_q;
  assign stall = (state_q != IDLE && state_q != FIN) || (state_q == IDLE && req);
endmodule
